// File: rtl/mmio_input_pkg.sv
// Shared definitions for the memory-mapped input bank.
// Holds the register offsets inside the 16-word window, the edge counter
// width with its saturation value, and a helper that sizes the CNT_SEL field.
package mmio_input_pkg;

  localparam logic [3:0] OFF_LEVEL   = 4'd0;
  localparam logic [3:0] OFF_RISE    = 4'd1;
  localparam logic [3:0] OFF_FALL    = 4'd2;
  localparam logic [3:0] OFF_OUT     = 4'd3;
  localparam logic [3:0] OFF_IRQ_EN  = 4'd4;
  localparam logic [3:0] OFF_CNT_SEL = 4'd5;
  localparam logic [3:0] OFF_CNT     = 4'd6;

  localparam int WINDOW = 16;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A single channel still needs a one-bit select field.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_input_bank_if.sv
// Data-memory bus slice seen by the input bank.
//   wren  : write enable          addr  : word address
//   wdata : write data            rdata : registered read data
//   hit   : registered, rdata comes from this block (RAM/IO mux select)
interface mmio_input_bank_if #(
  parameter int ADDR_W = 12
);
  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              hit;

  modport master (output wren, output addr, output wdata, input rdata, input hit);
  modport slave  (input wren, input addr, input wdata, output rdata, output hit);
endinterface

// File: rtl/input_debouncer.sv
// One input channel: two-flop synchroniser, stability counter and the
// accepted LEVEL flop.
//   clock, reset : system clock, synchronous active-low reset
//   in_raw       : asynchronous external input
//   level        : debounced level
//   rise_pulse   : high in the cycle whose edge moves level 0->1
//   fall_pulse   : high in the cycle whose edge moves level 1->0
module input_debouncer #(
  parameter int DEB_W      = 16,
  parameter int DEB_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic in_raw,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [DEB_W-1:0] deb_cnt;
  logic             flip;

  // The last required differing sample: level toggles on this edge.
  assign flip       = (sync_p1 != level) && (deb_cnt == CNT_LAST);
  assign rise_pulse = flip & ~level;
  assign fall_pulse = flip & level;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb_cnt <= '0;
      level   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter
      sync_p0 <= in_raw;
      sync_p1 <= sync_p0;
      // stage p1 -> level: stability qualification
      if (sync_p1 == level) begin
        deb_cnt <= '0;
      end else if (flip) begin
        deb_cnt <= '0;
        level   <= ~level;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_input_bank.sv
// Memory-mapped bank of N_IN debounced inputs and an N_OUT-bit output register.
// Sticky RISE/FALL flags, saturating 16-bit rising-edge counters per channel,
// maskable interrupt. Reads return one cycle after the address, like the RAM.
//   clock, reset : system clock, synchronous active-low reset
//   in_raw       : asynchronous external inputs
//   out          : output register contents
//   irq          : OR of (RISE|FALL) & IRQ_EN
//   bus          : data-memory bus slave (wren/addr/wdata/rdata/hit)
module mmio_input_bank
  import mmio_input_pkg::*;
#(
  parameter int                N_IN       = 8,
  parameter int                N_OUT      = 1,
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 12'hF00,
  parameter int                DEB_W      = 16,
  parameter int                DEB_CYCLES = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IN-1:0]  in_raw,
  output logic [N_OUT-1:0] out,
  output logic             irq,
  mmio_input_bank_if.slave bus
);

  localparam int SEL_W = sel_width(N_IN);

  logic [N_IN-1:0]       level;
  logic [N_IN-1:0]       rise_pulse;
  logic [N_IN-1:0]       fall_pulse;
  logic [N_IN-1:0]       rise_q;
  logic [N_IN-1:0]       fall_q;
  logic [N_IN-1:0]       irq_en_q;
  logic [SEL_W-1:0]      cnt_sel_q;
  logic [N_IN*CNT_W-1:0] cnt_q;

  logic [ADDR_W-1:0]     off_full;
  logic [3:0]            off;
  logic                  in_win;
  logic                  wr;
  logic [N_IN-1:0]       rise_w1c;
  logic [N_IN-1:0]       fall_w1c;
  logic [CNT_W-1:0]      cnt_rd;
  logic [31:0]           rd_mux;

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    input_debouncer #(
      .DEB_W     (DEB_W),
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock     (clock),
      .reset     (reset),
      .in_raw    (in_raw[g]),
      .level     (level[g]),
      .rise_pulse(rise_pulse[g]),
      .fall_pulse(fall_pulse[g])
    );
  end

  // Both checks are needed: the subtraction wraps for addresses below the base.
  assign off_full = bus.addr - BASE_ADDR;
  assign in_win   = (bus.addr >= BASE_ADDR) && (off_full < ADDR_W'(WINDOW));
  assign off      = off_full[3:0];
  assign wr       = bus.wren && in_win;

  assign rise_w1c = (wr && off == OFF_RISE) ? bus.wdata[N_IN-1:0] : '0;
  assign fall_w1c = (wr && off == OFF_FALL) ? bus.wdata[N_IN-1:0] : '0;

  assign irq = |((rise_q | fall_q) & irq_en_q);

  // A CNT_SEL that matches no channel selects nothing: reads 0, clears ignored.
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (32'(cnt_sel_q) == 32'(i)) cnt_rd = cnt_q[i*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_LEVEL:   rd_mux = 32'(level);
      OFF_RISE:    rd_mux = 32'(rise_q);
      OFF_FALL:    rd_mux = 32'(fall_q);
      OFF_OUT:     rd_mux = 32'(out);
      OFF_IRQ_EN:  rd_mux = 32'(irq_en_q);
      OFF_CNT_SEL: rd_mux = 32'(cnt_sel_q);
      OFF_CNT:     rd_mux = 32'(cnt_rd);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rise_q    <= '0;
      fall_q    <= '0;
      irq_en_q  <= '0;
      cnt_sel_q <= '0;
      cnt_q     <= '0;
      out       <= '0;
      bus.rdata <= '0;
      bus.hit   <= 1'b0;
    end else begin
      // New edge events are OR-ed in after the clear so they are never lost.
      rise_q <= (rise_q & ~rise_w1c) | rise_pulse;
      fall_q <= (fall_q & ~fall_w1c) | fall_pulse;

      if (wr && off == OFF_OUT)     out       <= bus.wdata[N_OUT-1:0];
      if (wr && off == OFF_IRQ_EN)  irq_en_q  <= bus.wdata[N_IN-1:0];
      if (wr && off == OFF_CNT_SEL) cnt_sel_q <= bus.wdata[SEL_W-1:0];

      for (int i = 0; i < N_IN; i++) begin
        if (wr && off == OFF_CNT && 32'(cnt_sel_q) == 32'(i)) begin
          // A rise in the clearing cycle counts as the first edge.
          cnt_q[i*CNT_W +: CNT_W] <= CNT_W'(rise_pulse[i]);
        end else if (rise_pulse[i] && cnt_q[i*CNT_W +: CNT_W] != CNT_MAX) begin
          cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end

      // read stage boundary: data sampled before this edge's writes
      bus.rdata <= in_win ? rd_mux : '0;
      bus.hit   <= in_win;
    end
  end

endmodule

// File: doc/mmio_input_bank.md
Name: mmio_input_bank

Overview:
- Parametrised, memory-mapped successor to the fixed eight 1-bit sensor inputs and single 1-bit output at the processor/top-level boundary.
- Synchronises and debounces N_IN external inputs and latches sticky rise/fall flags.
- Counts rising edges per channel, drives an N_OUT-bit output register and raises a maskable interrupt.
- Sits on the processor data-memory bus beside the RAM and responds only inside its address window.

Parameters:
- N_IN, 8, number of input channels (1..32)
- N_OUT, 1, output register width (1..32)
- ADDR_W, 12, data-bus address width (word address)
- BASE_ADDR, 12'hF00, first word address of the register window
- DEB_W, 16, debounce counter width
- DEB_CYCLES, 1000, consecutive stable cycles required to accept a new level (1..2^DEB_W-1)

Ports:
- clock  in  1  system clock, all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- in_raw  in  N_IN  asynchronous external inputs
- out  out  N_OUT  output register contents
- wren  in  1  bus write enable
- addr  in  ADDR_W  bus word address
- wdata  in  32  bus write data
- rdata  out  32  registered read data
- hit  out  1  registered; rdata is valid from this block (select for the RAM/IO mux)
- irq  out  1  OR of (RISE|FALL) & IRQ_EN

Behaviour:
- Reset (reset==0 at a clock edge): sync flops, LEVEL, RISE, FALL, OUT, IRQ_EN, CNT_SEL, debounce counters and edge counters all clear. Outputs after reset: rdata=0, hit=0, irq=0, out=0.
- Synchroniser: two flops per channel. The sync output reflects in_raw two edges later.
- Debounce, per channel:
  - The counter increments each cycle that sync != LEVEL.
  - Any cycle with sync == LEVEL clears the counter.
  - When the counter == DEB_CYCLES-1 and sync != LEVEL, LEVEL toggles at that edge and the counter clears.
  - Net latency: LEVEL changes DEB_CYCLES cycles after the first differing sync sample, i.e. 2+DEB_CYCLES edges after a clean in_raw step.
  - A glitch shorter than DEB_CYCLES sync cycles never changes LEVEL.
- Edge events: a LEVEL 0->1 transition sets RISE[i] and increments CNT[i]. A LEVEL 1->0 transition sets FALL[i].
- Edge counters: CNT[i] is 16-bit and saturates at 16'hFFFF.
- Register map (offset = addr - BASE_ADDR):
  - 0 LEVEL: read-only.
  - 1 RISE: write-1-to-clear.
  - 2 FALL: write-1-to-clear.
  - 3 OUT: read/write, N_OUT LSBs.
  - 4 IRQ_EN: read/write, N_IN LSBs.
  - 5 CNT_SEL: read/write, clog2(N_IN) LSBs (min 1).
  - 6 CNT: read returns CNT[CNT_SEL]; any write clears CNT[CNT_SEL].
  - Offsets 7..15 read 0 and ignore writes.
- Window: offsets 0..15. Outside the window: no state change, and next cycle hit=0, rdata=0.
- Read latency: 1 cycle. For addr in the window at edge t, rdata and hit are valid after edge t+1, matching the synchronous RAM. Write cycles also assert hit and return the pre-write value.
- Unused upper bits of every register read as 0. Write data above a field's width is ignored.
- Simultaneous events:
  - Set wins over W1C in the same cycle.
  - A CNT clear in the same cycle as a rise leaves CNT=1.
  - Increment at 16'hFFFF stays at 16'hFFFF.
  - Writing CNT_SEL affects CNT reads from the next cycle onward.
  - CNT_SEL >= N_IN reads CNT as 0, and a write to CNT is then ignored.
- irq is combinational from registered state. It drops the cycle after the clearing write.
- Reset mid-debounce discards the partial count. An input held high through reset re-qualifies and sets RISE after 2+DEB_CYCLES edges.

Decomposition:
- Package mmio_input_pkg: register offset localparams (OFF_LEVEL..OFF_CNT, WINDOW=16), CNT_W=16, CNT_MAX.
- Sub-module input_debouncer, one instance per channel via generate:
  - Contains the synchroniser, debounce counter and LEVEL flop.
  - Outputs level, rise_pulse and fall_pulse.
  - Top level holds the flags, edge counters, bus decode and read mux.

Test Plan:
1. DEB_CYCLES=4; release reset with in_raw=0, then step in_raw[3] 0->1 -> LEVEL[3]=1 exactly 6 edges later. Read offset 1 -> 32'h8 one cycle after the read. irq=0 until IRQ_EN=32'h8 is written, then irq=1.
2. DEB_CYCLES=4; pulse in_raw[0] high for 3 cycles -> LEVEL, RISE and CNT stay 0. Then hold in_raw[0] high for 20 cycles -> RISE[0]=1 and CNT[0]=1.
3. Write 32'h8 to offset 1 in the same cycle as a new rise on channel 3 -> RISE[3] still 1. A write on a quiet cycle clears it and drops irq the next cycle.
4. Write 32'hFFFF_FFFF to offset 3 with N_OUT=1 -> out=1 and readback 32'h1. Read address BASE_ADDR+16 -> hit=0, rdata=0.
5. CNT_SEL=2; toggle in_raw[2] five times -> CNT read 5. Write offset 6 in the same cycle as a 6th rise -> CNT=1. Force the count to 16'hFFFF and add a rise -> CNT stays 16'hFFFF.
6. Assert reset (0) mid-debounce with in_raw[1] held at 1 -> all registers read 0 after release. RISE[1] sets 2+DEB_CYCLES edges after release.
